mmio_initiator: RTL and testbench

Host-side MMIO request initiator for the CCI-P MMIO path: the requester counterpart to our AFU MMIO responder. It accepts single read/write commands on a valid/ready port and issues one-cycle MMIO write or read request pulses with a 9-bit transaction ID (TID). It matches returning read responses by TID and delivers read data or an error code on a result port. It drives the AFU in simulation benches and in loopback/self-test builds, with one read outstanding at a time.

---
 rtl/mmio_initiator.sv | 167 ++++++++++++++++
 tb/tb_mmio_initiator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_initiator.sv
// Host-side MMIO requester: turns single read/write commands into one-cycle
// MMIO request pulses and returns TID-matched read results or error codes.
module mmio_initiator #(
  parameter int         TIMEOUT  = 256,
  parameter logic [8:0] TID_INIT = 9'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [63:0] cmd_data,
  output logic        mmio_wr_valid,
  output logic        mmio_rd_valid,
  output logic [15:0] mmio_addr,
  output logic [8:0]  mmio_tid,
  output logic [63:0] mmio_data,
  input  logic        rsp_valid,
  input  logic [8:0]  rsp_tid,
  input  logic [63:0] rsp_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic [1:0]  res_err,
  output logic [7:0]  stray_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_BAD_ADDR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESULT} state_t;

  state_t        state_q, state_d;
  logic          wr_q, wr_d;
  logic [8:0]    tid_q, tid_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          mmio_wr_valid_q, mmio_wr_valid_d;
  logic          mmio_rd_valid_q, mmio_rd_valid_d;
  logic [15:0]   mmio_addr_q, mmio_addr_d;
  logic [8:0]    mmio_tid_q, mmio_tid_d;
  logic [63:0]   mmio_data_q, mmio_data_d;
  logic          res_valid_q, res_valid_d;
  logic [63:0]   res_data_q, res_data_d;
  logic [1:0]    res_err_q, res_err_d;
  logic [7:0]    stray_cnt_q, stray_cnt_d;
  logic          stray_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      wr_q            <= 1'b0;
      tid_q           <= TID_INIT;
      timer_q         <= '0;
      mmio_wr_valid_q <= 1'b0;
      mmio_rd_valid_q <= 1'b0;
      mmio_addr_q     <= '0;
      mmio_tid_q      <= '0;
      mmio_data_q     <= '0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
      res_err_q       <= ERR_OK;
      stray_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      wr_q            <= wr_d;
      tid_q           <= tid_d;
      timer_q         <= timer_d;
      mmio_wr_valid_q <= mmio_wr_valid_d;
      mmio_rd_valid_q <= mmio_rd_valid_d;
      mmio_addr_q     <= mmio_addr_d;
      mmio_tid_q      <= mmio_tid_d;
      mmio_data_q     <= mmio_data_d;
      res_valid_q     <= res_valid_d;
      res_data_q      <= res_data_d;
      res_err_q       <= res_err_d;
      stray_cnt_q     <= stray_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wr_d            = wr_q;
    tid_d           = tid_q;
    timer_d         = timer_q;
    mmio_wr_valid_d = 1'b0;
    mmio_rd_valid_d = 1'b0;
    mmio_addr_d     = mmio_addr_q;
    mmio_tid_d      = mmio_tid_q;
    mmio_data_d     = mmio_data_q;
    res_valid_d     = res_valid_q;
    res_data_d      = res_data_q;
    res_err_d       = res_err_q;
    stray_hit       = rsp_valid && (state_q != S_WAIT);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_addr[0]) begin
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_err_d   = ERR_BAD_ADDR;
            state_d     = S_RESULT;
          end else begin
            // The request pulse is registered here so it appears in the ISSUE cycle.
            wr_d            = cmd_wr;
            mmio_wr_valid_d = cmd_wr;
            mmio_rd_valid_d = !cmd_wr;
            mmio_addr_d     = cmd_addr;
            mmio_tid_d      = cmd_wr ? mmio_tid_q : tid_q;
            mmio_data_d     = cmd_wr ? cmd_data : 64'd0;
            state_d         = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = wr_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (rsp_valid && (rsp_tid == tid_q)) begin
          res_valid_d = 1'b1;
          res_data_d  = rsp_data;
          res_err_d   = ERR_OK;
          tid_d       = tid_q + 9'd1;
          state_d     = S_RESULT;
        end else begin
          stray_hit = rsp_valid;
          if (timer_q == TIMER_LAST) begin
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_err_d   = ERR_TIMEOUT;
            tid_d       = tid_q + 9'd1;
            state_d     = S_RESULT;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    stray_cnt_d = (stray_hit && (stray_cnt_q != 8'hFF)) ? stray_cnt_q + 8'd1 : stray_cnt_q;
  end

  assign cmd_ready     = (state_q == S_IDLE) && rst_n;
  assign mmio_wr_valid = mmio_wr_valid_q;
  assign mmio_rd_valid = mmio_rd_valid_q;
  assign mmio_addr     = mmio_addr_q;
  assign mmio_tid      = mmio_tid_q;
  assign mmio_data     = mmio_data_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_err       = res_err_q;
  assign stray_cnt     = stray_cnt_q;

endmodule

// File: tb/tb_mmio_initiator.sv
// Directed bench for mmio_initiator with TIMEOUT=8; expected values are hand-derived cycle by cycle.
module tb_mmio_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic        mmio_wr_valid;
  logic        mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_data;
  logic        rsp_valid = 1'b0;
  logic [8:0]  rsp_tid = '0;
  logic [63:0] rsp_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic [1:0]  res_err;
  logic [7:0]  stray_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  mmio_initiator #(.TIMEOUT(8), .TID_INIT(9'h000)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_data(mmio_data),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .stray_cnt(stray_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge: inputs and samples live there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command in cycle N and leave the bench in cycle N+1 with cmd_valid dropped.
  task automatic accept(input logic wr, input logic [15:0] addr, input logic [63:0] data);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_data  = data;
    check("cmd_ready_at_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_mmio_valid", {mmio_wr_valid, mmio_rd_valid}, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_err", res_err, 0);
    check("rst_stray", stray_cnt, 0);
    check("rst_mmio_addr", mmio_addr, 0);
    rst_n = 1'b1;
    tick();
    check("idle_cmd_ready", cmd_ready, 1);
    $display("[TB] reset checked");

    // Write 0x20
    accept(1'b1, 16'h0020, 64'hDEADBEEF_CAFEF00D);
    check("wr_pulse", mmio_wr_valid, 1);
    check("wr_no_rd", mmio_rd_valid, 0);
    check("wr_addr", mmio_addr, 16'h0020);
    check("wr_data", mmio_data, 64'hDEADBEEF_CAFEF00D);
    check("wr_busy", cmd_ready, 0);
    tick();
    check("wr_pulse_end", mmio_wr_valid, 0);
    check("wr_ready_n2", cmd_ready, 1);
    check("wr_no_result", res_valid, 0);
    $display("[TB] write 0x20 done");

    // Read 0x20, response TID 0 at N+3
    accept(1'b0, 16'h0020, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rd0_pulse", mmio_rd_valid, 1);
    check("rd0_no_wr", mmio_wr_valid, 0);
    check("rd0_tid", mmio_tid, 0);
    check("rd0_data_zero", mmio_data, 0);
    check("rd0_addr", mmio_addr, 16'h0020);
    tick();
    check("rd0_pulse_end", mmio_rd_valid, 0);
    check("rd0_busy", cmd_ready, 0);
    tick();
    rsp_valid = 1'b1; rsp_tid = 9'd0; rsp_data = 64'h1234;
    check("rd0_no_res_yet", res_valid, 0);
    tick();
    rsp_valid = 1'b0;
    check("rd0_res_valid", res_valid, 1);
    check("rd0_res_data", res_data, 64'h1234);
    check("rd0_res_err", res_err, 2'b00);
    check("rd0_stray", stray_cnt, 0);
    tick();
    check("rd0_hold_valid", res_valid, 1);
    check("rd0_hold_data", res_data, 64'h1234);
    check("rd0_hold_ready", cmd_ready, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("rd0_res_done", res_valid, 0);
    check("rd0_ready_back", cmd_ready, 1);
    $display("[TB] read 0x20 TID 0 done");

    // Read with no response: timeout at N+10, res_ready held high in advance
    accept(1'b0, 16'h0040, 64'd0);
    check("to_tid", mmio_tid, 1);
    res_ready = 1'b1;
    for (int c = 2; c <= 9; c++) tick();
    check("to_not_yet", res_valid, 0);
    tick();
    check("to_res_valid", res_valid, 1);
    check("to_res_err", res_err, 2'b01);
    check("to_res_data", res_data, 0);
    tick();
    res_ready = 1'b0;
    check("to_res_done", res_valid, 0);
    check("to_ready_back", cmd_ready, 1);
    rsp_valid = 1'b1; rsp_tid = 9'd0; rsp_data = 64'h55;
    tick();
    rsp_valid = 1'b0;
    check("to_late_stray", stray_cnt, 1);
    $display("[TB] timeout read done");

    // Response in the last window cycle (timer == TIMEOUT-1) wins over timeout
    accept(1'b0, 16'h0048, 64'd0);
    check("edge_tid", mmio_tid, 2);
    for (int c = 2; c <= 9; c++) tick();
    rsp_valid = 1'b1; rsp_tid = 9'd2; rsp_data = 64'hA5A5;
    tick();
    rsp_valid = 1'b0;
    check("edge_res_valid", res_valid, 1);
    check("edge_res_err", res_err, 2'b00);
    check("edge_res_data", res_data, 64'hA5A5);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    $display("[TB] match at timeout boundary done");

    // Odd address read and write: no pulse, BAD_ADDR at N+1
    accept(1'b0, 16'h0021, 64'd0);
    check("bad_rd_no_pulse", {mmio_wr_valid, mmio_rd_valid}, 0);
    check("bad_rd_res_valid", res_valid, 1);
    check("bad_rd_res_err", res_err, 2'b10);
    check("bad_rd_res_data", res_data, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bad_rd_ready_back", cmd_ready, 1);
    accept(1'b1, 16'h0023, 64'h77);
    check("bad_wr_no_pulse", {mmio_wr_valid, mmio_rd_valid}, 0);
    check("bad_wr_res_err", res_err, 2'b10);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    $display("[TB] bad address done");

    // Mismatched TID 5 then matching TID 3
    accept(1'b0, 16'h0050, 64'd0);
    check("mm_tid_unchanged_by_bad", mmio_tid, 3);
    tick();
    rsp_valid = 1'b1; rsp_tid = 9'd5; rsp_data = 64'hBAD;
    tick();
    rsp_tid = 9'd3; rsp_data = 64'h600D;
    check("mm_stray_after_5", stray_cnt, 2);
    check("mm_still_waiting", res_valid, 0);
    tick();
    rsp_valid = 1'b0;
    check("mm_res_valid", res_valid, 1);
    check("mm_res_data", res_data, 64'h600D);
    check("mm_res_err", res_err, 2'b00);
    check("mm_stray_final", stray_cnt, 2);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    $display("[TB] mismatch then match done");

    // 300 unexpected responses saturate stray_cnt
    rsp_valid = 1'b1; rsp_tid = 9'd7;
    for (int c = 0; c < 300; c++) tick();
    rsp_valid = 1'b0;
    check("stray_saturated", stray_cnt, 255);
    $display("[TB] stray saturation done");

    // TID wrap: reads with TIDs 4..511, 0, 1
    for (int i = 0; i < 510; i++) begin
      logic [8:0] exp_tid;
      exp_tid = 9'(4 + i);
      accept(1'b0, 16'h0100, 64'd0);
      check("wrap_tid", mmio_tid, exp_tid);
      tick();
      rsp_valid = 1'b1; rsp_tid = exp_tid; rsp_data = 64'(i);
      tick();
      rsp_valid = 1'b0;
      res_ready = 1'b1;
      if (exp_tid == 9'd511 || exp_tid == 9'd0) begin
        check("wrap_res_err", res_err, 2'b00);
        check("wrap_res_data", res_data, 64'(i));
      end
      tick();
      res_ready = 1'b0;
    end
    $display("[TB] TID wrap done");

    // Asynchronous reset in WAIT
    accept(1'b0, 16'h0200, 64'd0);
    check("rw_tid", mmio_tid, 2);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rw_cmd_ready", cmd_ready, 0);
    check("rw_mmio_valid", {mmio_wr_valid, mmio_rd_valid}, 0);
    check("rw_mmio_addr", mmio_addr, 0);
    check("rw_mmio_tid", mmio_tid, 0);
    check("rw_res_valid", res_valid, 0);
    check("rw_stray", stray_cnt, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("rw_ready_after", cmd_ready, 1);
    accept(1'b0, 16'h0208, 64'd0);
    check("rw_first_tid", mmio_tid, 0);
    tick();
    rsp_valid = 1'b1; rsp_tid = 9'd0; rsp_data = 64'hC0FFEE;
    tick();
    rsp_valid = 1'b0;
    check("rw_res_data", res_data, 64'hC0FFEE);
    check("rw_res_err", res_err, 2'b00);
    $display("[TB] reset during WAIT done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
